// File: rtl/wb_pkg.sv
// wb_pkg: shared write-back queue types and the RegFile-matching default widths.
// Contents: WB_W (data width), WB_D (register pointer width), wb_entry_t (one queue slot).
package wb_pkg;
  localparam int WB_W = 8;
  localparam int WB_D = 4;
  typedef struct packed {
    logic            valid;
    logic [WB_D-1:0] addr;
    logic [WB_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_search.sv
// wb_fwd_search: finds the youngest valid queue entry whose address matches raddr_i.
// Ports: ent_i (queue slots), head_i (oldest slot), raddr_i (lookup address),
//        hit_o (any valid match), data_o (youngest matching data, 0 if no hit).
module wb_fwd_search
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                  ent_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [WB_D-1:0]            raddr_i,
  output logic                       hit_o,
  output logic [WB_W-1:0]            data_o
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  // Walk oldest to youngest from head so the last match seen is the newest value.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (ent_i[idx].valid && ent_i[idx].addr == raddr_i) begin
        hit_o  = 1'b1;
        data_o = ent_i[idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: write-back FIFO draining into RegFile one entry per cycle, with operand forwarding.
// Ports: Clk/Reset (sync, active-high), Flush; InValid/InReady/InAddr/InData push side;
//        DrainEn/WriteEn/Waddr/DataOut RegFile side; RaddrA/B -> HitA/B, FwdA/B lookups;
//        Count occupancy, Empty.
// Build option: define WB_FORWARD_EN to build the forwarding search; otherwise Hit/Fwd are 0.
module wb_queue
  import wb_pkg::*;
#(
  parameter int W     = WB_W,
  parameter int D     = WB_D,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [D-1:0]             InAddr,
  input  logic [W-1:0]             InData,
  input  logic                     DrainEn,
  output logic                     WriteEn,
  output logic [D-1:0]             Waddr,
  output logic [W-1:0]             DataOut,
  input  logic [D-1:0]             RaddrA,
  input  logic [D-1:0]             RaddrB,
  output logic                     HitA,
  output logic                     HitB,
  output logic [W-1:0]             FwdA,
  output logic [W-1:0]             FwdB,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t     ent_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  assign Empty   = count_q == '0;
  assign Count   = count_q;
  assign WriteEn = !Empty && DrainEn && !Flush;
  assign pop     = WriteEn;
  // A full queue still accepts when the head drains in the same cycle.
  assign InReady = !Flush && (count_q < CW'(DEPTH) || WriteEn);
  assign push    = InValid && InReady;
  assign Waddr   = Empty ? '0 : ent_q[head_q].addr;
  assign DataOut = Empty ? '0 : ent_q[head_q].data;
  assign count_d = count_q + CW'(push) - CW'(pop);
  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      // Clear before set: when full, head and tail coincide on a push+pop cycle.
      if (pop) begin
        ent_q[head_q].valid <= 1'b0;
        head_q <= head_q + 1'b1;
      end
      if (push) begin
        ent_q[tail_q] <= '{valid: 1'b1, addr: InAddr, data: InData};
        tail_q <= tail_q + 1'b1;
      end
      count_q <= count_d;
    end
  end
`ifdef WB_FORWARD_EN
  wb_fwd_search #(.DEPTH(DEPTH)) u_fwd_a (
    .ent_i(ent_q), .head_i(head_q), .raddr_i(RaddrA), .hit_o(HitA), .data_o(FwdA)
  );
  wb_fwd_search #(.DEPTH(DEPTH)) u_fwd_b (
    .ent_i(ent_q), .head_i(head_q), .raddr_i(RaddrB), .hit_o(HitB), .data_o(FwdB)
  );
`else
  assign HitA = 1'b0;
  assign HitB = 1'b0;
  assign FwdA = '0;
  assign FwdB = '0;
`endif
endmodule
